// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared op and state types for the load/store stack controller
package lsu_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01,
        PUSH  = 2'b10,
        POP   = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_stack_ptr.sv
// rtl/lsu_stack_ptr.sv - descending stack pointer with full/empty guards
module lsu_stack_ptr
    import lsu_pkg::*;
#(
    parameter int ADDR_SIZE   = 5,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push_i,
    input  logic                 pop_i,
    output logic [ADDR_SIZE-1:0] sp_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [ADDR_SIZE-1:0] BASE  = ADDR_SIZE'((2 ** ADDR_SIZE) - 1);
    localparam logic [ADDR_SIZE-1:0] LIMIT = ADDR_SIZE'((2 ** ADDR_SIZE) - 1 - STACK_DEPTH);

    logic [ADDR_SIZE-1:0] sp_q;
    logic [ADDR_SIZE-1:0] sp_d;

    assign full_o  = (sp_q == LIMIT);
    assign empty_o = (sp_q == BASE);
    assign sp_o    = sp_q;

    // Guards keep the pointer inside the stack region even if a strobe slips through
    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q - ADDR_SIZE'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_q + ADDR_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sp_q <= BASE;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/lsu_stack_ctrl.sv
// rtl/lsu_stack_ctrl.sv - load/store/push/pop front-end for the data memory
// Optional macro LSU_ERR_STICKY_EN adds the err_sticky output.
module lsu_stack_ctrl
    import lsu_pkg::*;
#(
    parameter int DATA_SIZE   = 8,
    parameter int ADDR_SIZE   = 5,
    parameter int STACK_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_SIZE-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [ADDR_SIZE-1:0] sp,
    output logic                 mem_w,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wdata,
    input  logic [DATA_SIZE-1:0] mem_rdata
`ifdef LSU_ERR_STICKY_EN
    ,
    output logic                 err_sticky
`endif
);

    lsu_state_e           state_q;
    lsu_op_e              op_q;
    logic                 err_q;
    logic                 mem_w_q;
    logic [ADDR_SIZE-1:0] mem_addr_q;
    logic [DATA_SIZE-1:0] mem_wdata_q;
    logic                 rsp_valid_q;
    logic [DATA_SIZE-1:0] rsp_data_q;
    logic                 rsp_err_q;

    lsu_op_e              req_op_e;
    logic [ADDR_SIZE-1:0] eff_addr_d;
    logic                 acc_err_d;
    logic                 sp_full;
    logic                 sp_empty;
    logic                 sp_push;
    logic                 sp_pop;

    assign req_op_e = lsu_op_e'(req_op);

    always_comb begin
        eff_addr_d = req_addr;
        case (req_op_e)
            PUSH:    eff_addr_d = sp;
            POP:     eff_addr_d = sp + ADDR_SIZE'(1);
            default: eff_addr_d = req_addr;
        endcase
    end

    assign acc_err_d = ((req_op_e == PUSH) && sp_full) || ((req_op_e == POP) && sp_empty);

    // Pointer moves on the edge that ends ACCESS, together with the memory write/read
    assign sp_push = (state_q == ACCESS) && (op_q == PUSH) && !err_q;
    assign sp_pop  = (state_q == ACCESS) && (op_q == POP) && !err_q;

    lsu_stack_ptr #(
        .ADDR_SIZE   (ADDR_SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack_ptr (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (sp_push),
        .pop_i   (sp_pop),
        .sp_o    (sp),
        .full_o  (sp_full),
        .empty_o (sp_empty)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            op_q        <= LOAD;
            err_q       <= 1'b0;
            mem_w_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op_e;
                        err_q       <= acc_err_d;
                        mem_addr_q  <= eff_addr_d;
                        mem_wdata_q <= req_wdata;
                        mem_w_q     <= ((req_op_e == STORE) || (req_op_e == PUSH)) && !acc_err_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_w_q     <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err_q;
                    rsp_data_q  <= (((op_q == LOAD) || (op_q == POP)) && !err_q) ? mem_rdata : '0;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = rstn && (state_q == IDLE);
    assign mem_w     = rstn && mem_w_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

`ifdef LSU_ERR_STICKY_EN
    logic err_sticky_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_sticky_q <= 1'b0;
        end else if ((state_q == ACCESS) && err_q) begin
            err_sticky_q <= 1'b1;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_lsu_stack_ctrl.sv
// tb/tb_lsu_stack_ctrl.sv - scoreboard bench for lsu_stack_ctrl with a memory model
module tb_lsu_stack_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int BASE  = 31;

    localparam logic [1:0] OP_LD = 2'b00;
    localparam logic [1:0] OP_ST = 2'b01;
    localparam logic [1:0] OP_PU = 2'b10;
    localparam logic [1:0] OP_PO = 2'b11;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] sp;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef LSU_ERR_STICKY_EN
    logic          err_sticky;
`endif

    always #5 clk = ~clk;

    lsu_stack_ctrl #(
        .DATA_SIZE   (DW),
        .ADDR_SIZE   (AW),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sp        (sp),
        .mem_w     (mem_w),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef LSU_ERR_STICKY_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    // Data memory: asynchronous read, write on the clock edge while W is high
    logic [DW-1:0] mem [32] = '{default: '0};
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_w) mem[mem_addr] <= mem_wdata;

    // Reference model: flat memory image plus stack occupancy
    logic [DW-1:0] ref_mem [32] = '{default: '0};
    int            depth       = 0;
    int            exp_writes  = 0;
    logic          ref_sticky  = 1'b0;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            acc;
    } exp_t;
    exp_t sb[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   writes = 0;
    int   last_waddr = -1;
    logic hold_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rsp_ready = hold_low ? 1'b0 : ($urandom_range(3) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: response checking, hold stability, latency and write counting
    logic          pv = 1'b0, pr = 1'b0, phs = 1'b0, pe = 1'b0;
    logic [DW-1:0] pd = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            pv = 1'b0; pr = 1'b0; phs = 1'b0;
        end else begin
            if (mem_w) begin
                writes++;
                last_waddr = int'(mem_addr);
            end
            if (pv && !pr) begin
                chk("rsp_held_valid", {31'd0, rsp_valid}, 32'd1);
                chk("rsp_held_data", {24'd0, rsp_data}, {24'd0, pd});
                chk("rsp_held_err", {31'd0, rsp_err}, {31'd0, pe});
            end
            if (phs) begin
                chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
                chk("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
            end
            if (rsp_valid) begin
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
                end else begin
                    if (!pv) chk("rsp_latency", 32'(cyc - sb[0].acc), 32'd2);
                    if (rsp_ready) begin
                        e = sb.pop_front();
                        chk("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
                        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                    end
                end
            end
            phs = rsp_valid && rsp_ready;
            pv  = rsp_valid;
            pr  = rsp_ready;
            pd  = rsp_data;
            pe  = rsp_err;
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got 0 expected 1 (t=%0t)", $time);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        wait_ready();
        if (!req_ready) return;
        chk("sp_before_op", {27'd0, sp}, 32'(BASE - depth));
`ifdef LSU_ERR_STICKY_EN
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, ref_sticky});
`endif
        e.err  = 1'b0;
        e.data = '0;
        case (op)
            OP_LD: e.data = ref_mem[addr];
            OP_ST: begin
                ref_mem[addr] = data;
                exp_writes++;
            end
            OP_PU: begin
                if (depth == DEPTH) e.err = 1'b1;
                else begin
                    ref_mem[BASE - depth] = data;
                    depth++;
                    exp_writes++;
                end
            end
            default: begin
                if (depth == 0) e.err = 1'b1;
                else begin
                    depth--;
                    e.data = ref_mem[BASE - depth];
                end
            end
        endcase
        if (e.err) ref_sticky = 1'b1;
        e.acc = cyc;
        sb.push_back(e);
        req_op    = op;
        req_addr  = addr;
        req_wdata = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || !req_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {24'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_mem_w"}, {31'd0, mem_w}, 32'd0);
        chk({tag, "_mem_addr"}, {27'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, {24'd0, mem_wdata}, 32'd0);
        chk({tag, "_sp"}, {27'd0, sp}, 32'(BASE));
`ifdef LSU_ERR_STICKY_EN
        chk({tag, "_err_sticky"}, {31'd0, err_sticky}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int w0;
        logic [DW-1:0] m9;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rstn = 1'b1;

        // STORE then LOAD of the same address
        w0 = writes;
        issue(OP_ST, 5'd5, 8'hA5);
        wait_idle();
        chk("store_one_write", 32'(writes - w0), 32'd1);
        chk("store_waddr", 32'(last_waddr), 32'd5);
        issue(OP_LD, 5'd5, 8'h00);
        wait_idle();

        // Basic push/pop round trip
        issue(OP_PU, 5'd0, 8'h11);
        issue(OP_PU, 5'd0, 8'h22);
        issue(OP_PO, 5'd0, 8'h00);
        issue(OP_PO, 5'd0, 8'h00);
        wait_idle();
        chk("sp_after_roundtrip", {27'd0, sp}, 32'(BASE));

        // Underflow
        w0 = writes;
        issue(OP_PO, 5'd0, 8'h00);
        wait_idle();
        chk("underflow_no_write", 32'(writes - w0), 32'd0);
        chk("sp_after_underflow", {27'd0, sp}, 32'(BASE));

        // Fill the stack, then overflow
        for (int i = 0; i < DEPTH; i++) issue(OP_PU, 5'd0, 8'(8'h40 + i));
        wait_idle();
        chk("sp_full", {27'd0, sp}, 32'(BASE - DEPTH));
        w0 = writes;
        issue(OP_PU, 5'd0, 8'hEE);
        wait_idle();
        chk("overflow_no_write", 32'(writes - w0), 32'd0);
        chk("sp_after_overflow", {27'd0, sp}, 32'(BASE - DEPTH));
        chk("mem23_kept", {24'd0, mem[23]}, {24'd0, ref_mem[23]});
`ifdef LSU_ERR_STICKY_EN
        chk("err_sticky_set", {31'd0, err_sticky}, 32'd1);
`endif
        for (int i = 0; i < DEPTH; i++) issue(OP_PO, 5'd0, 8'h00);
        wait_idle();

        // LOAD with the consumer stalling
        hold_low = 1'b1;
        issue(OP_LD, 5'd23, 8'h00);
        begin
            int n = 0;
            while (!rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("stall_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        end
        repeat (3) @(posedge clk);
        hold_low = 1'b0;
        wait_idle();

        // Reset in the middle of ACCESS of a STORE
        wait_ready();
        m9 = mem[9];
        req_op    = OP_ST;
        req_addr  = 5'd9;
        req_wdata = 8'h3C;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rstn = 1'b0;
        #1;
        chk("abort_mem_w", {31'd0, mem_w}, 32'd0);
        @(posedge clk);
        #1;
        chk("abort_mem9", {24'd0, mem[9]}, {24'd0, m9});
        chk_reset_outputs("abort");
        depth = 0;
        ref_sticky = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);

        // Randomized traffic, biased toward stack ops to hit both boundaries
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            op = ($urandom_range(3) == 0) ? 2'($urandom_range(1)) : 2'(2 + $urandom_range(1));
            issue(op, AW'($urandom), DW'($urandom));
        end
        wait_idle();

        chk("total_writes", 32'(writes), 32'(exp_writes));
        for (int a = 0; a < 32; a++) begin
            if (mem[a] !== ref_mem[a]) begin
                tests++;
                fails++;
                $display("FAIL mem_image[%0d]: got %0h expected %0h", a, mem[a], ref_mem[a]);
            end else begin
                tests++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
